// File: rtl/cu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 19-bit CPU control unit: sequencer state
// encoding, opcode map, flag bit positions and opcode-class helpers.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } cu_state_t;

  localparam logic [4:0] OP_LOAD  = 5'h10;
  localparam logic [4:0] OP_STORE = 5'h11;
  localparam logic [4:0] OP_JMP   = 5'h12;
  localparam logic [4:0] OP_JZ    = 5'h13;
  localparam logic [4:0] OP_JNZ   = 5'h14;
  localparam logic [4:0] OP_JC    = 5'h15;
  localparam logic [4:0] OP_NOP   = 5'h1E;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  // ALU operations occupy the whole lower half of the opcode space.
  function automatic logic is_alu(input logic [4:0] opc);
    return ~opc[4];
  endfunction

  // Anything not listed here raises the illegal pulse in EXEC.
  function automatic logic is_defined(input logic [4:0] opc);
    logic ok;
    ok = is_alu(opc);
    case (opc)
      OP_LOAD, OP_STORE, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_NOP, OP_HALT: ok = 1'b1;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cu_sequencer_if
// Control bus between the sequencer (master) and the endpoints that feed it
// and obey its strobes (slave): memory, PC, register file, ALU.
//   enable, opcode, flags, mem_ack        : endpoint -> sequencer
//   rd_en, wr_en, ir_load, inc_pc, pc_load,
//   load_reg, mode, halted, fault, illegal : sequencer -> endpoints
// ---------------------------------------------------------------------------
interface cu_sequencer_if #(
  parameter int OPC_W = 5,
  parameter int FLG_W = 4
);
  logic             enable;
  logic [OPC_W-1:0] opcode;
  logic [FLG_W-1:0] flags;
  logic             mem_ack;
  logic             rd_en;
  logic             wr_en;
  logic             ir_load;
  logic             inc_pc;
  logic             pc_load;
  logic             load_reg;
  logic             mode;
  logic             halted;
  logic             fault;
  logic             illegal;

  modport master (
    input  enable, opcode, flags, mem_ack,
    output rd_en, wr_en, ir_load, inc_pc, pc_load, load_reg, mode,
           halted, fault, illegal
  );

  modport slave (
    output enable, opcode, flags, mem_ack,
    input  rd_en, wr_en, ir_load, inc_pc, pc_load, load_reg, mode,
           halted, fault, illegal
  );
endinterface

// File: rtl/cu_sequencer_wait_timer.sv
// ---------------------------------------------------------------------------
// cu_wait_timer
// Counts cycles spent waiting for mem_ack in a memory request state and flags
// the last allowed cycle.
//   clk, rst  : clock, synchronous active-high reset
//   waiting   : sequencer is in FETCH / MEM_RD / MEM_WR
//   ack       : mem_ack from memory
//   expired   : this is request cycle number MEM_TIMEOUT; no ack now -> FAULT
// ---------------------------------------------------------------------------
module cu_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic expired
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // An ack always leaves the current request state, so clearing on ack (or
  // whenever not waiting) guarantees a zero count on entry to any request
  // state, including MEM_WR -> FETCH back-to-back.
  always_ff @(posedge clk) begin
    if (rst || !waiting || ack) cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end

  // The FSM checks ack before expired, so an ack on the last cycle wins.
  assign expired = waiting && (cnt == LAST);
endmodule

// File: rtl/cu_sequencer.sv
// ---------------------------------------------------------------------------
// cu_sequencer
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 19-bit CPU.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cu_sequencer_if.master
//          in : enable, opcode, flags {V,N,C,Z}, mem_ack
//          out: rd_en, wr_en, ir_load, inc_pc, pc_load, load_reg, mode,
//               halted, fault, illegal
// Strobes are registered decodes of the next state, so they are Moore
// functions of the state register; ir_load alone is FETCH & mem_ack.
// ---------------------------------------------------------------------------
module cu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int OPC_W       = 5,
  parameter int FLG_W       = 4
) (
  input logic           clk,
  input logic           rst,
  cu_sequencer_if.master bus
);
  cu_state_t        state;
  cu_state_t        state_nxt;
  cu_state_t        boundary_nxt;
  logic [OPC_W-1:0] opc;
  logic [FLG_W-1:0] flg;
  logic             waiting;
  logic             expired;
  logic             unused_flags;

  logic rd_en_r, wr_en_r, inc_pc_r, pc_load_r, load_reg_r, mode_r;
  logic halted_r, fault_r, illegal_r;

  assign opc          = bus.opcode;
  assign flg          = bus.flags;
  assign unused_flags = ^{flg[FLG_V], flg[FLG_N]};

  function automatic logic branch_taken(input logic [4:0] o, input logic z, input logic c);
    case (o)
      OP_JMP:  return 1'b1;
      OP_JZ:   return z;
      OP_JNZ:  return ~z;
      OP_JC:   return c;
      default: return 1'b0;
    endcase
  endfunction

  assign waiting = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

  cu_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ack     (bus.mem_ack),
    .expired (expired)
  );

  // enable is only looked at here and in IDLE, so dropping it mid-instruction
  // lets the instruction run to completion.
  assign boundary_nxt = bus.enable ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.enable) state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.mem_ack) state_nxt = ST_DECODE;
                 else if (expired) state_nxt = ST_FAULT;
      ST_DECODE: if (opc == OP_LOAD)       state_nxt = ST_MEM_RD;
                 else if (opc == OP_STORE) state_nxt = ST_MEM_WR;
                 else                      state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (opc == OP_HALT) ? ST_HALT : boundary_nxt;
      ST_MEM_RD: if (bus.mem_ack) state_nxt = ST_WB;
                 else if (expired) state_nxt = ST_FAULT;
      ST_WB:     state_nxt = boundary_nxt;
      ST_MEM_WR: if (bus.mem_ack) state_nxt = boundary_nxt;
                 else if (expired) state_nxt = ST_FAULT;
      ST_HALT:   state_nxt = ST_HALT;
      ST_FAULT:  state_nxt = ST_FAULT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // EXEC strobes are computed from opcode/flags as seen in DECODE; both are
  // held stable across DECODE and EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      inc_pc_r   <= 1'b0;
      pc_load_r  <= 1'b0;
      load_reg_r <= 1'b0;
      mode_r     <= 1'b0;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_en_r    <= (state_nxt == ST_FETCH) || (state_nxt == ST_MEM_RD);
      wr_en_r    <= (state_nxt == ST_MEM_WR);
      inc_pc_r   <= (state_nxt == ST_DECODE);
      pc_load_r  <= (state_nxt == ST_EXEC) && branch_taken(opc, flg[FLG_Z], flg[FLG_C]);
      load_reg_r <= (state_nxt == ST_WB) || ((state_nxt == ST_EXEC) && is_alu(opc));
      mode_r     <= (state_nxt == ST_EXEC) && is_alu(opc) && opc[3];
      halted_r   <= (state_nxt == ST_HALT);
      fault_r    <= (state_nxt == ST_FAULT);
      illegal_r  <= (state_nxt == ST_EXEC) && !is_defined(opc);
    end
  end

  assign bus.rd_en    = rd_en_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.ir_load  = (state == ST_FETCH) && bus.mem_ack;
  assign bus.inc_pc   = inc_pc_r;
  assign bus.pc_load  = pc_load_r;
  assign bus.load_reg = load_reg_r;
  assign bus.mode     = mode_r;
  assign bus.halted   = halted_r;
  assign bus.fault    = fault_r;
  assign bus.illegal  = illegal_r;
endmodule

// File: tb/tb_cu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cu_sequencer
// Drives instruction-level scenarios (directed, then randomized) and compares
// every cycle's output vector with a schedule derived from the instruction
// timing rules: fetch wait + ack, decode, then exec / mem-read + writeback /
// mem-write, followed by boundary, halt or fault behaviour.
// ---------------------------------------------------------------------------
module tb_cu_sequencer;
  import cpu_pkg::*;

  localparam int MEM_TO = 5;

  typedef logic [9:0] ovec_t;
  // Output vector bit order: rd_en wr_en ir_load inc_pc pc_load load_reg mode halted fault illegal
  localparam ovec_t RD   = 10'h200;
  localparam ovec_t WR   = 10'h100;
  localparam ovec_t IRL  = 10'h080;
  localparam ovec_t INC  = 10'h040;
  localparam ovec_t PCL  = 10'h020;
  localparam ovec_t LR   = 10'h010;
  localparam ovec_t MD   = 10'h008;
  localparam ovec_t HLT  = 10'h004;
  localparam ovec_t FLT  = 10'h002;
  localparam ovec_t ILL  = 10'h001;
  localparam ovec_t NONE = 10'h000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cu_sequencer_if #(.OPC_W(5), .FLG_W(4)) bus ();

  cu_sequencer #(.MEM_TIMEOUT(MEM_TO), .OPC_W(5), .FLG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ovec_t obs;
  assign obs = {bus.rd_en, bus.wr_en, bus.ir_load, bus.inc_pc, bus.pc_load,
                bus.load_reg, bus.mode, bus.halted, bus.fault, bus.illegal};

  int n_run  = 0;
  int n_fail = 0;
  bit idle   = 1'b1;
  bit dead   = 1'b0;

  task automatic chk(input string tag, input ovec_t got, input ovec_t exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h (rd wr irl inc pcl lr md hlt flt ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock: apply inputs after the falling edge, sample settled outputs.
  task automatic cyc(input string tag, input logic en, input logic [4:0] opc,
                     input logic [3:0] flg, input logic ack, input ovec_t exp);
    @(negedge clk);
    rst         = 1'b0;
    bus.enable  = en;
    bus.opcode  = opc;
    bus.flags   = flg;
    bus.mem_ack = ack;
    #1;
    chk(tag, obs, exp);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst         = 1'b1;
      bus.enable  = rb();
      bus.mem_ack = rb();
      bus.opcode  = 5'($urandom);
      bus.flags   = 4'($urandom);
    end
    idle = 1'b1;
    dead = 1'b0;
  endtask

  // Expected strobes during the single EXEC cycle.
  function automatic ovec_t exec_exp(input logic [4:0] o, input logic [3:0] f);
    if (o < 5'h10) return (o >= 5'h08) ? (LR | MD) : LR;
    case (o)
      5'h12:        return PCL;
      5'h13:        return f[0] ? PCL : NONE;
      5'h14:        return f[0] ? NONE : PCL;
      5'h15:        return f[1] ? PCL : NONE;
      5'h10, 5'h11,
      5'h1E, 5'h1F: return NONE;
      default:      return ILL;
    endcase
  endfunction

  // A request state: d cycles with no ack, then the ack cycle; d >= MEM_TO
  // means the memory never answers in time and the sequencer must fault.
  task automatic wait_phase(input string tag, input int d, input ovec_t strobe,
                            input ovec_t on_ack, input logic en_ack,
                            input logic [4:0] o, input logic [3:0] f,
                            output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i < d && i < MEM_TO; i++)
      cyc({tag, "_wait"}, rb(), o, f, 1'b0, strobe);
    if (d >= MEM_TO) begin
      faulted = 1'b1;
      dead    = 1'b1;
      for (int i = 0; i < 3; i++) cyc({tag, "_fault"}, 1'b1, o, f, rb(), FLT);
    end else begin
      cyc({tag, "_ack"}, en_ack, o, f, 1'b1, strobe | on_ack);
    end
  endtask

  task automatic run_instr(input string tag, input logic [4:0] o, input logic [3:0] f,
                           input int fd, input int md, input logic en_end);
    bit flt;
    if (idle) begin
      if (rb()) cyc({tag, "_idle0"}, 1'b0, 5'($urandom), 4'($urandom), rb(), NONE);
      cyc({tag, "_idle"}, 1'b1, 5'($urandom), 4'($urandom), rb(), NONE);
      idle = 1'b0;
    end
    wait_phase({tag, "_fetch"}, fd, RD, IRL, rb(), 5'($urandom), 4'($urandom), flt);
    if (flt) return;
    cyc({tag, "_decode"}, rb(), o, f, rb(), INC);
    if (o == OP_LOAD) begin
      wait_phase({tag, "_memrd"}, md, RD, NONE, rb(), o, f, flt);
      if (flt) return;
      cyc({tag, "_wb"}, en_end, o, f, rb(), LR);
      idle = !en_end;
    end else if (o == OP_STORE) begin
      wait_phase({tag, "_memwr"}, md, WR, NONE, en_end, o, f, flt);
      if (flt) return;
      idle = !en_end;
    end else begin
      cyc({tag, "_exec"}, en_end, o, f, rb(), exec_exp(o, f));
      if (o == OP_HALT) begin
        dead = 1'b1;
        for (int i = 0; i < 3; i++)
          cyc({tag, "_halt"}, 1'b1, 5'($urandom), 4'($urandom), rb(), HLT);
      end else begin
        idle = !en_end;
      end
    end
  endtask

  initial begin
    logic [4:0] o;
    int         fd, md, sel;

    bus.enable  = 1'b0;
    bus.opcode  = '0;
    bus.flags   = '0;
    bus.mem_ack = 1'b0;
    do_reset(2);

    // Reset in the middle of a LOAD's memory read.
    cyc("rst_idle",  1'b1, OP_LOAD, 4'h0, 1'b0, NONE);
    cyc("rst_fetch", 1'b1, OP_LOAD, 4'h0, 1'b1, RD | IRL);
    cyc("rst_dec",   1'b1, OP_LOAD, 4'h0, 1'b0, INC);
    cyc("rst_memrd", 1'b1, OP_LOAD, 4'h0, 1'b0, RD);
    do_reset(2);
    run_instr("add",      5'h01, 4'h0,    0, 0, 1'b1);
    run_instr("and",      5'h09, 4'h0,    0, 0, 1'b1);
    run_instr("jz_t",     OP_JZ, 4'b0001, 0, 0, 1'b1);
    run_instr("jz_nt",    OP_JZ, 4'b0000, 0, 0, 1'b1);
    run_instr("jnz",      OP_JNZ, 4'b0000, 1, 0, 1'b1);
    run_instr("jc",       OP_JC, 4'b0010, 0, 0, 1'b1);
    run_instr("jmp",      OP_JMP, 4'b0000, 0, 0, 1'b1);
    run_instr("load",     OP_LOAD, 4'h0,  0, 4, 1'b1);
    run_instr("store",    OP_STORE, 4'h0, 2, 0, 1'b1);
    run_instr("ack_last", 5'h03, 4'h0, MEM_TO - 1, 0, 1'b1);
    run_instr("illegal",  5'h1A, 4'h0,    0, 0, 1'b1);
    run_instr("nop",      OP_NOP, 4'hF,   0, 0, 1'b0);
    run_instr("en_low",   5'h02, 4'h0,    0, 0, 1'b0);
    run_instr("to_fetch", 5'h01, 4'h0, MEM_TO, 0, 1'b1);
    do_reset(2);
    run_instr("to_memwr", OP_STORE, 4'h0, 0, MEM_TO, 1'b1);
    do_reset(1);
    run_instr("halt",     OP_HALT, 4'h0,  0, 0, 1'b1);
    do_reset(2);

    for (int n = 0; n < 300; n++) begin
      if (dead) do_reset($urandom_range(1, 2));
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: o = 5'($urandom_range(0, 15));
        3:       o = 5'($urandom_range(18, 21));
        4:       o = OP_LOAD;
        5:       o = OP_STORE;
        6:       o = OP_NOP;
        7:       o = 5'($urandom_range(22, 29));
        8:       o = ($urandom_range(0, 3) == 0) ? OP_HALT : 5'($urandom_range(0, 15));
        default: o = 5'($urandom);
      endcase
      fd = ($urandom_range(0, 15) == 0) ? $urandom_range(MEM_TO - 1, MEM_TO)
                                        : $urandom_range(0, 2);
      md = ($urandom_range(0, 11) == 0) ? $urandom_range(MEM_TO - 1, MEM_TO)
                                        : $urandom_range(0, 3);
      run_instr("rnd", o, 4'($urandom), fd, md, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
